// File: rtl/transaccion_pkg.sv
// Shared types and sizing helpers for the transaccion_param transaction layer.
package transaccion_pkg;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_e;

  localparam int AE_THR_RST = 1;

  function automatic int dest_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int af_thr_rst(input int depth);
    return depth - 1;
  endfunction

endpackage

// File: rtl/transaccion_param_if.sv
// Bundle of the transaction-layer signals between the producer/consumer side
// (master) and the transaccion_param block (slave).
interface transaccion_param_if #(
  parameter int NUM_CH = 4,
  parameter int WORD_W = 10,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 5
);
  import transaccion_pkg::*;

  localparam int DEST_W = dest_w(NUM_CH);
  localparam int PTR_W  = ptr_w(DEPTH);

  // push_in/pop_out are single-cycle strobes with no ready: a push into a full
  // input FIFO is lost (flagged by error) unless the arbiter pops it the same
  // cycle; almost_full_in is the upstream backpressure hint.
  logic                       init;
  logic [PTR_W-1:0]           almost_empty_thr;
  logic [PTR_W-1:0]           almost_full_thr;
  logic [NUM_CH-1:0]          push_in;
  logic [NUM_CH*WORD_W-1:0]   data_in;
  logic [NUM_CH-1:0]          pop_out;
  logic                       req;
  logic [DEST_W-1:0]          idx;
  logic [NUM_CH*WORD_W-1:0]   data_out;
  logic [NUM_CH-1:0]          empty_out;
  logic [NUM_CH-1:0]          almost_empty_out;
  logic [NUM_CH-1:0]          almost_full_in;
  logic [CNT_W-1:0]           data;
  logic                       valid;
  logic [2:0]                 state;
  logic                       error;

  modport master (
    output init, almost_empty_thr, almost_full_thr, push_in, data_in,
           pop_out, req, idx,
    input  data_out, empty_out, almost_empty_out, almost_full_in,
           data, valid, state, error
  );

  modport slave (
    input  init, almost_empty_thr, almost_full_thr, push_in, data_in,
           pop_out, req, idx,
    output data_out, empty_out, almost_empty_out, almost_full_in,
           data, valid, state, error
  );

endinterface

// File: rtl/transaccion_param_fifo.sv
// fifo_param: first-word fall-through FIFO; a push into a full FIFO is only
// accepted when a pop frees the slot on the same edge.
module fifo_param
  import transaccion_pkg::*;
#(
  parameter int  WORD_W = 10,
  parameter int  DEPTH  = 8,
  localparam int PTR_W  = ptr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [WORD_W-1:0] data_i,
  output logic [WORD_W-1:0] data_o,
  output logic [PTR_W:0]    count_o,
  output logic              full_o,
  output logic              empty_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign count_o = count_q;
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
    else if (!push_ok && pop_ok) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; data_o masks it while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/transaccion_param.sv
// Transaction layer: NUM_CH input FIFOs routed by destination field into NUM_CH
// output FIFOs. Define TRANS_RR_ARB_EN for round-robin arbitration (default: fixed priority).
module transaccion_param
  import transaccion_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int WORD_W = 10,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 5
) (
  input  logic                clk,
  input  logic                reset,
  transaccion_param_if.slave  bus
);

  localparam int DEST_W = dest_w(NUM_CH);
  localparam int PTR_W  = ptr_w(DEPTH);

  state_e                         state_q, state_d;
  logic [PTR_W-1:0]               ae_thr_q, ae_thr_d;
  logic [PTR_W-1:0]               af_thr_q, af_thr_d;
  logic [NUM_CH-1:0][CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]               data_q, data_d;
  logic                           valid_q, valid_d;
  logic                           error_q, error_d;

  logic [NUM_CH-1:0]              in_empty, in_full, in_pop;
  logic [NUM_CH-1:0]              out_empty, out_push;
  logic [NUM_CH-1:0][WORD_W-1:0]  in_head, out_head;
  logic [NUM_CH-1:0][PTR_W:0]     in_count, out_count;
  logic [NUM_CH-1:0]              eligible;
  logic                           grant_vld;
  logic [DEST_W-1:0]              grant_idx, grant_dest;
  logic [WORD_W-1:0]              xfer_word;
  logic                           overflow;
  logic                           xfer_en, thr_load, rd_en, err_en;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    fifo_param #(.WORD_W(WORD_W), .DEPTH(DEPTH)) u_in (
      .clk     (clk),
      .reset   (reset),
      .push_i  (bus.push_in[k]),
      .pop_i   (in_pop[k]),
      .data_i  (bus.data_in[k*WORD_W +: WORD_W]),
      .data_o  (in_head[k]),
      .count_o (in_count[k]),
      .full_o  (in_full[k]),
      .empty_o (in_empty[k])
    );

    fifo_param #(.WORD_W(WORD_W), .DEPTH(DEPTH)) u_out (
      .clk     (clk),
      .reset   (reset),
      .push_i  (out_push[k]),
      .pop_i   (bus.pop_out[k]),
      .data_i  (xfer_word),
      .data_o  (out_head[k]),
      .count_o (out_count[k]),
      .full_o  (),
      .empty_o (out_empty[k])
    );

    assign bus.data_out[k*WORD_W +: WORD_W] = out_head[k];
    assign bus.almost_empty_out[k]          = (out_count[k] <= {1'b0, ae_thr_q});
    assign bus.almost_full_in[k]            = (in_count[k] >= {1'b0, af_thr_q});
  end

  // A channel may move only if its head's destination is below the almost-full mark.
  always_comb begin
    eligible = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      eligible[k] = !in_empty[k] &&
                    (out_count[in_head[k][WORD_W-1 -: DEST_W]] < {1'b0, af_thr_q});
    end
  end

`ifdef TRANS_RR_ARB_EN
  logic [DEST_W-1:0] rr_ptr_q;
  logic [DEST_W-1:0] cand;

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int i = NUM_CH-1; i >= 0; i--) begin
      cand = rr_ptr_q + DEST_W'(i);
      if (xfer_en && eligible[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)          rr_ptr_q <= '0;
    else if (grant_vld) rr_ptr_q <= grant_idx + 1'b1;
  end
`else
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = NUM_CH-1; i >= 0; i--) begin
      if (xfer_en && eligible[i]) begin
        grant_vld = 1'b1;
        grant_idx = DEST_W'(i);
      end
    end
  end
`endif

  assign xfer_word  = in_head[grant_idx];
  assign grant_dest = xfer_word[WORD_W-1 -: DEST_W];

  always_comb begin
    in_pop   = '0;
    out_push = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      in_pop[i]   = grant_vld && (grant_idx == DEST_W'(i));
      out_push[i] = grant_vld && (grant_dest == DEST_W'(i));
    end
  end

  assign overflow = |(bus.push_in & in_full & ~in_pop);

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_RESET;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET: state_d = ST_INIT;
      ST_INIT: begin
        if (overflow)      state_d = ST_ERROR;
        else if (!bus.init) state_d = ST_IDLE;
      end
      ST_IDLE, ST_ACTIVE: begin
        if (overflow)        state_d = ST_ERROR;
        else if (bus.init)   state_d = ST_INIT;
        else if (~&in_empty) state_d = ST_ACTIVE;
        else                 state_d = ST_IDLE;
      end
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_ERROR;
    endcase
  end

  always_comb begin
    xfer_en  = (state_q == ST_ACTIVE);
    thr_load = (state_q == ST_INIT);
    rd_en    = (state_q == ST_IDLE) || (state_q == ST_ACTIVE) || (state_q == ST_ERROR);
    err_en   = (state_q != ST_RESET);
  end

  // Counter read samples cnt_q, so a same-cycle increment is not yet visible.
  always_comb begin
    ae_thr_d = thr_load ? bus.almost_empty_thr : ae_thr_q;
    af_thr_d = thr_load ? bus.almost_full_thr  : af_thr_q;
    for (int d = 0; d < NUM_CH; d++) begin
      cnt_d[d] = cnt_q[d] + CNT_W'(out_push[d]);
    end
    valid_d = bus.req && rd_en;
    data_d  = valid_d ? cnt_q[bus.idx] : data_q;
    error_d = error_q | (overflow & err_en);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ae_thr_q <= PTR_W'(AE_THR_RST);
      af_thr_q <= PTR_W'(af_thr_rst(DEPTH));
      cnt_q    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      ae_thr_q <= ae_thr_d;
      af_thr_q <= af_thr_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
    end
  end

  assign bus.empty_out = out_empty;
  assign bus.data      = data_q;
  assign bus.valid     = valid_q;
  assign bus.state     = state_q;
  assign bus.error     = error_q;

endmodule

// File: tb/tb_transaccion_param.sv
// Bench for transaccion_param: directed phases plus random traffic, checked
// cycle by cycle against a queue-based reference model.
module tb_transaccion_param;

  localparam int NUM_CH = 4;
  localparam int WORD_W = 10;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 5;
  localparam int DEST_W = 2;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  transaccion_param_if #(.NUM_CH(NUM_CH), .WORD_W(WORD_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  transaccion_param #(.NUM_CH(NUM_CH), .WORD_W(WORD_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference model: words held in plain queues, one entry per buffered word.
  logic [WORD_W-1:0] m_in  [NUM_CH][$];
  logic [WORD_W-1:0] exp_q [NUM_CH][$];
  int m_cnt [NUM_CH];
  int m_state, m_ae, m_af, m_data, m_rr;
  bit m_err, m_valid;
  int n_cmp, n_bad;

  function automatic int dest_of(input logic [WORD_W-1:0] w);
    return int'(w[WORD_W-1 -: DEST_W]);
  endfunction

  function automatic bit can_move(input int c);
    if (m_in[c].size() == 0) return 1'b0;
    return exp_q[dest_of(m_in[c][0])].size() < m_af;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [NUM_CH*WORD_W-1:0] e_data;
    logic [NUM_CH-1:0] e_empty, e_ae, e_af;
    e_data = '0;
    for (int d = 0; d < NUM_CH; d++) begin
      e_empty[d] = (exp_q[d].size() == 0);
      e_ae[d]    = (exp_q[d].size() <= m_ae);
      e_af[d]    = (m_in[d].size() >= m_af);
      if (exp_q[d].size() != 0) e_data[d*WORD_W +: WORD_W] = exp_q[d][0];
    end
    chk("state", 64'(bus.state), 64'(m_state));
    chk("error", 64'(bus.error), 64'(m_err));
    chk("valid", 64'(bus.valid), 64'(m_valid));
    chk("data", 64'(bus.data), 64'(m_data));
    chk("empty_out", 64'(bus.empty_out), 64'(e_empty));
    chk("data_out", 64'(bus.data_out), 64'(e_data));
    chk("almost_empty_out", 64'(bus.almost_empty_out), 64'(e_ae));
    chk("almost_full_in", 64'(bus.almost_full_in), 64'(e_af));
  endtask

  // One clock: predict the effect of the current inputs, clock, then compare.
  task automatic step();
    int win, nxt, d;
    bit ovf, any_in;
    logic [WORD_W-1:0] w;
    if (reset) begin
      for (int k = 0; k < NUM_CH; k++) begin
        m_in[k].delete();
        exp_q[k].delete();
        m_cnt[k] = 0;
      end
      m_state = 0; m_ae = 1; m_af = DEPTH - 1;
      m_err = 0; m_data = 0; m_valid = 0; m_rr = 0;
    end else begin
      win = -1;
      if (m_state == 3) begin
`ifdef TRANS_RR_ARB_EN
        for (int i = 0; i < NUM_CH; i++)
          if (win < 0 && can_move((m_rr + i) % NUM_CH)) win = (m_rr + i) % NUM_CH;
`else
        for (int c = 0; c < NUM_CH; c++)
          if (win < 0 && can_move(c)) win = c;
`endif
      end
      ovf = 0; any_in = 0;
      for (int k = 0; k < NUM_CH; k++) begin
        if (bus.push_in[k] && m_in[k].size() == DEPTH && win != k) ovf = 1;
        if (m_in[k].size() != 0) any_in = 1;
      end
      case (m_state)
        0: nxt = 1;
        1: nxt = ovf ? 4 : (bus.init ? 1 : 2);
        2, 3: nxt = ovf ? 4 : (bus.init ? 1 : (any_in ? 3 : 2));
        default: nxt = 4;
      endcase
      if (bus.req && m_state >= 2) begin
        m_data = m_cnt[bus.idx]; m_valid = 1;
      end else m_valid = 0;
      for (int k = 0; k < NUM_CH; k++)
        if (bus.pop_out[k] && exp_q[k].size() != 0) void'(exp_q[k].pop_front());
      if (win >= 0) begin
        w = m_in[win].pop_front();
        d = dest_of(w);
        exp_q[d].push_back(w);
        m_cnt[d] = (m_cnt[d] + 1) % (1 << CNT_W);
        m_rr = (win + 1) % NUM_CH;
      end
      for (int k = 0; k < NUM_CH; k++)
        if (bus.push_in[k] && m_in[k].size() < DEPTH) m_in[k].push_back(bus.data_in[k*WORD_W +: WORD_W]);
      if (m_state == 1) begin
        m_ae = int'(bus.almost_empty_thr);
        m_af = int'(bus.almost_full_thr);
      end
      if (ovf && m_state != 0) m_err = 1;
      m_state = nxt;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    bus.push_in = '0;
    bus.data_in = NUM_CH*WORD_W'($urandom);
    bus.pop_out = '0;
    bus.req     = 1'b0;
    bus.idx     = '0;
    bus.init    = 1'b0;
  endtask

  task automatic set_push(input int ch, input logic [WORD_W-1:0] w);
    bus.push_in[ch] = 1'b1;
    bus.data_in[ch*WORD_W +: WORD_W] = w;
  endtask

  task automatic reset_and_init(input int ae, input int af);
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    step();
    bus.init = 1'b1;
    bus.almost_empty_thr = 3'(ae);
    bus.almost_full_thr  = 3'(af);
    step(); step();
    bus.init = 1'b0;
    step(); step();
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    bus.almost_empty_thr = 3'd0;
    bus.almost_full_thr  = 3'd0;
    idle_inputs();

    // Reset and threshold load 2/6.
    reset_and_init(2, 6);

    // Single word ch0 -> dest 1, then drain it.
    set_push(0, 10'h105);
    step();
    idle_inputs();
    repeat (4) step();
    bus.pop_out[1] = 1'b1;
    step();
    idle_inputs();

    // All four inputs to dest 2 in one cycle, then read count[2].
    reset_and_init(2, 6);
    for (int k = 0; k < NUM_CH; k++) set_push(k, {2'd2, 8'($urandom)});
    step();
    idle_inputs();
    repeat (8) step();
    bus.req = 1'b1; bus.idx = 2'd2;
    step();
    idle_inputs();
    step();
    for (int i = 0; i < 5; i++) begin
      bus.pop_out[2] = 1'b1;
      step();
    end
    idle_inputs();

    // ch0 floods dest 3 with no output pops until overflow.
    for (int i = 0; i < 20; i++) begin
      idle_inputs();
      set_push(0, {2'd3, 8'($urandom)});
      step();
    end
    idle_inputs();
    bus.req = 1'b1; bus.idx = 2'd3;
    step();
    idle_inputs();

    // Reset while in ERROR with traffic still arriving.
    set_push(1, {2'd0, 8'($urandom)});
    reset = 1'b1;
    step();
    reset = 1'b0;
    idle_inputs();
    step();

    // ch0 and ch1 kept busy together, outputs drained.
    reset_and_init(2, 6);
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 6; i++) begin
        idle_inputs();
        bus.pop_out = '1;
        if (i < 3) begin
          set_push(0, 10'($urandom));
          set_push(1, 10'($urandom));
        end
        step();
      end
    end
    idle_inputs();

    // Random traffic with occasional re-init.
    for (int seg = 0; seg < 2; seg++) begin
      reset_and_init($urandom_range(0, 7), $urandom_range(3, 7));
      for (int i = 0; i < 250; i++) begin
        idle_inputs();
        for (int k = 0; k < NUM_CH; k++) begin
          if ($urandom_range(0, 4) == 0) set_push(k, 10'($urandom));
          bus.pop_out[k] = ($urandom_range(0, 1) == 1);
        end
        bus.req = ($urandom_range(0, 3) == 0);
        bus.idx = 2'($urandom_range(0, NUM_CH - 1));
        if ($urandom_range(0, 49) == 0) begin
          bus.init = 1'b1;
          bus.almost_empty_thr = 3'($urandom_range(0, 7));
          bus.almost_full_thr  = 3'($urandom_range(3, 7));
        end
        step();
      end
      idle_inputs();
      for (int k = 0; k < NUM_CH; k++) begin
        bus.req = 1'b1; bus.idx = 2'(k);
        step();
      end
      idle_inputs();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
